// File: rtl/ysyx_22050854_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshake, register file write port and scoreboard access.
// The arbiter uses the slave modport; the execute/issue side uses master.
interface ysyx_22050854_wb_arbiter_if #(
   parameter int NREQ = 3,
   parameter int XLEN = 64
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [5*NREQ-1:0]    req_rd;
   logic [XLEN*NREQ-1:0] req_data;

   logic                 rf_wen;
   logic [4:0]           rf_waddr;
   logic [XLEN-1:0]      rf_wdata;

   logic                 sb_set_valid;
   logic [4:0]           sb_set_rd;
   logic [4:0]           sb_q_rs1;
   logic [4:0]           sb_q_rs2;
   logic [4:0]           sb_q_rd;
   logic                 sb_busy_rs1;
   logic                 sb_busy_rs2;
   logic                 sb_busy_rd;

   modport master (
      output req_valid, req_rd, req_data,
      output sb_set_valid, sb_set_rd, sb_q_rs1, sb_q_rs2, sb_q_rd,
      input  req_ready,
      input  rf_wen, rf_waddr, rf_wdata,
      input  sb_busy_rs1, sb_busy_rs2, sb_busy_rd
   );

   modport slave (
      input  req_valid, req_rd, req_data,
      input  sb_set_valid, sb_set_rd, sb_q_rs1, sb_q_rs2, sb_q_rd,
      output req_ready,
      output rf_wen, rf_waddr, rf_wdata,
      output sb_busy_rs1, sb_busy_rs2, sb_busy_rd
   );
endinterface

// File: rtl/ysyx_22050854_wb_arbiter.sv
// Round-robin write-back arbiter onto the single register file write port, plus a
// busy-bit scoreboard of pending destination registers for RAW/WAW stalls.
module ysyx_22050854_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   ysyx_22050854_wb_arbiter_if.slave     bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW    = PTR_W + 1;

   logic [4:0]      req_rd_a   [NREQ];
   logic [XLEN-1:0] req_data_a [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign req_rd_a[gi]   = bus.req_rd[5*gi +: 5];
         assign req_data_a[gi] = bus.req_data[XLEN*gi +: XLEN];
      end
   endgenerate

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             rf_wen_q, rf_wen_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
   logic [31:0]      busy_q, busy_d;

   logic [NREQ-1:0]  grant_oh;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_any;
   logic [CW-1:0]    cand;
   logic [4:0]       sel_rd;
   logic             do_write;

   // Search from rr_ptr upward with wraparound; the first valid requester wins.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = CW'(rr_ptr_q) + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!grant_any && bus.req_valid[cand[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = cand[PTR_W-1:0];
         end
      end
      if (grant_any) begin
         grant_oh[grant_idx] = 1'b1;
      end
   end

   assign bus.req_ready = grant_oh;

   // The output slot is always free, so every grant is an accept.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      sel_rd     = req_rd_a[grant_idx];
      do_write   = grant_any && (sel_rd != 5'd0);
      rf_wen_d   = do_write;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (do_write) begin
         rf_waddr_d = sel_rd;
         rf_wdata_d = req_data_a[grant_idx];
      end
   end

   // Clear first, then set: a same-register set on the commit edge keeps the bit busy.
   always_comb begin
      busy_d = busy_q;
      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (bus.sb_set_valid && (bus.sb_set_rd != 5'd0)) begin
         busy_d[bus.sb_set_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.rf_wen   = rf_wen_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

   // No bypass: a register being written this cycle still reads busy.
   assign bus.sb_busy_rs1 = busy_q[bus.sb_q_rs1];
   assign bus.sb_busy_rs2 = busy_q[bus.sb_q_rs2];
   assign bus.sb_busy_rd  = busy_q[bus.sb_q_rd];
endmodule

// File: tb/tb_ysyx_22050854_wb_arbiter.sv
// Directed and random bench for the write-back arbiter, checked against a behavioural model.
module tb_ysyx_22050854_wb_arbiter;
   localparam int NREQ = 3;
   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ysyx_22050854_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

   ysyx_22050854_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total  = 0;
   int passed = 0;

   // Behavioural model: pointer, busy set, pending write slot.
   int         m_rr;
   bit [31:0]  m_busy;
   bit         m_wen;
   bit [4:0]   m_waddr;
   bit [63:0]  m_wdata;
   int         last_grant;
   int         rr_exp [6] = '{1, 2, 3, 1, 2, 3};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_rr = 0; m_busy = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
   endtask

   function automatic int exp_grant(input logic [2:0] v, input int rr);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (rr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input bit v, input bit [4:0] rd, input bit [63:0] d);
      bus.req_valid[i]         = v;
      bus.req_rd[5*i +: 5]     = rd;
      bus.req_data[64*i +: 64] = d;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0; bus.req_rd = '0; bus.req_data = '0;
      bus.sb_set_valid = 1'b0; bus.sb_set_rd = '0;
      bus.sb_q_rs1 = '0; bus.sb_q_rs2 = '0; bus.sb_q_rd = '0;
   endtask

   // Check one cycle at the falling edge, then advance the model across the rising edge.
   task automatic run_cycle();
      int         g;
      logic [2:0] e;
      @(negedge clk);
      g = exp_grant(bus.req_valid, m_rr);
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      check("req_ready", bus.req_ready, e);
      check("rf_wen", bus.rf_wen, m_wen);
      check("rf_waddr", bus.rf_waddr, m_waddr);
      check("rf_wdata", bus.rf_wdata, m_wdata);
      check("busy_rs1", bus.sb_busy_rs1, m_busy[bus.sb_q_rs1]);
      check("busy_rs2", bus.sb_busy_rs2, m_busy[bus.sb_q_rs2]);
      check("busy_rd", bus.sb_busy_rd, m_busy[bus.sb_q_rd]);
      if (bus.sb_set_valid && bus.sb_set_rd != 0 && bus.sb_q_rd == bus.sb_set_rd)
         check("set_legal", bus.sb_busy_rd, 1'b0);
      last_grant = g;
      @(posedge clk);
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (bus.sb_set_valid && bus.sb_set_rd != 0) m_busy[bus.sb_set_rd] = 1'b1;
      if (g >= 0) begin
         m_rr = (g + 1) % NREQ;
         if (bus.req_rd[5*g +: 5] != 0) begin
            m_wen   = 1'b1;
            m_waddr = bus.req_rd[5*g +: 5];
            m_wdata = bus.req_data[64*g +: 64];
         end else begin
            m_wen = 1'b0;
         end
      end else begin
         m_wen = 1'b0;
      end
      #1;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      last_grant = -1;

      // Power-on reset
      bus.sb_q_rs1 = 5'd5;
      #1;
      check("por_wen", bus.rf_wen, 1'b0);
      check("por_waddr", bus.rf_waddr, 5'd0);
      check("por_wdata", bus.rf_wdata, 64'd0);
      check("por_busy", bus.sb_busy_rs1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single write: set rd=5 at t0, ALU writes at t2, commit at t3
      bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd5; bus.sb_q_rd = 5'd5;
      run_cycle();
      bus.sb_set_valid = 1'b0;
      run_cycle();
      check("single_busy_t2", bus.sb_busy_rs1, 1'b1);
      set_req(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
      #1;
      check("single_ready", bus.req_ready, 3'b001);
      run_cycle();
      set_req(0, 1'b0, 5'd0, 64'd0);
      check("single_wen", bus.rf_wen, 1'b1);
      check("single_waddr", bus.rf_waddr, 5'd5);
      check("single_wdata", bus.rf_wdata, 64'hDEAD_BEEF);
      check("single_busy_t3", bus.sb_busy_rs1, 1'b1);
      run_cycle();
      check("single_busy_t4", bus.sb_busy_rs1, 1'b0);
      check("single_wen_t4", bus.rf_wen, 1'b0);
      run_cycle();

      // Round robin from a fresh pointer
      rst_n = 1'b0; #1; rst_n = 1'b1;
      model_reset();
      set_req(0, 1'b1, 5'd1, 64'hA1);
      set_req(1, 1'b1, 5'd2, 64'hB2);
      set_req(2, 1'b1, 5'd3, 64'hC3);
      for (int k = 0; k < 6; k++) begin
         run_cycle();
         check("rr_wen", bus.rf_wen, 1'b1);
         check("rr_waddr", bus.rf_waddr, 5'(rr_exp[k]));
      end
      clear_inputs();
      run_cycle();

      // Priority rotation: drive pointer to 2, then only 0 and 1 valid
      set_req(1, 1'b1, 5'd11, 64'h11);
      run_cycle();
      set_req(1, 1'b0, 5'd0, 64'd0);
      set_req(0, 1'b1, 5'd20, 64'h20);
      set_req(1, 1'b1, 5'd21, 64'h21);
      #1;
      check("prio_first", bus.req_ready, 3'b001);
      run_cycle();
      set_req(0, 1'b0, 5'd0, 64'd0);
      #1;
      check("prio_second", bus.req_ready, 3'b010);
      run_cycle();
      set_req(1, 1'b0, 5'd0, 64'd0);
      set_req(0, 1'b1, 5'd22, 64'h22);
      set_req(2, 1'b1, 5'd23, 64'h23);
      #1;
      check("prio_ptr2", bus.req_ready, 3'b100);
      run_cycle();
      set_req(2, 1'b0, 5'd0, 64'd0);
      run_cycle();
      set_req(0, 1'b0, 5'd0, 64'd0);
      run_cycle();

      // x0 handling
      set_req(0, 1'b1, 5'd0, 64'hFFFF);
      #1;
      check("x0_ready", bus.req_ready, 3'b001);
      run_cycle();
      set_req(0, 1'b0, 5'd0, 64'd0);
      check("x0_wen", bus.rf_wen, 1'b0);
      bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd0; bus.sb_q_rs2 = 5'd0;
      run_cycle();
      bus.sb_set_valid = 1'b0;
      check("x0_busy", bus.sb_busy_rs2, 1'b0);
      run_cycle();

      // Hazard boundary on register 7
      bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd7; bus.sb_q_rd = 5'd7; bus.sb_q_rs1 = 5'd7;
      run_cycle();
      bus.sb_set_valid = 1'b0;
      run_cycle();
      set_req(1, 1'b1, 5'd7, 64'h77);
      run_cycle();
      set_req(1, 1'b0, 5'd0, 64'd0);
      check("haz_wen", bus.rf_wen, 1'b1);
      check("haz_waddr", bus.rf_waddr, 5'd7);
      check("haz_busy_commit", bus.sb_busy_rs1, 1'b1);
      run_cycle();
      check("haz_busy_after", bus.sb_busy_rs1, 1'b0);
      bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd7;
      run_cycle();
      bus.sb_set_valid = 1'b0;
      check("haz_reset_busy", bus.sb_busy_rs1, 1'b1);

      // Asynchronous reset with a write in the output slot
      bus.sb_set_valid = 1'b1; bus.sb_set_rd = 5'd9; bus.sb_q_rd = 5'd9;
      run_cycle();
      bus.sb_set_valid = 1'b0;
      set_req(2, 1'b1, 5'd9, 64'h9999);
      run_cycle();
      set_req(2, 1'b0, 5'd0, 64'd0);
      bus.sb_q_rs1 = 5'd9; bus.sb_q_rs2 = 5'd7;
      #1;
      check("pre_rst_wen", bus.rf_wen, 1'b1);
      check("pre_rst_busy", bus.sb_busy_rs1, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst_wen", bus.rf_wen, 1'b0);
      check("rst_waddr", bus.rf_waddr, 5'd0);
      check("rst_wdata", bus.rf_wdata, 64'd0);
      check("rst_busy9", bus.sb_busy_rs1, 1'b0);
      check("rst_busy7", bus.sb_busy_rs2, 1'b0);
      set_req(1, 1'b1, 5'd3, 64'h33);
      set_req(2, 1'b1, 5'd4, 64'h44);
      #1;
      check("rst_ready", bus.req_ready, 3'b010);
      rst_n = 1'b1;
      model_reset();
      run_cycle();
      set_req(1, 1'b0, 5'd0, 64'd0);
      run_cycle();
      clear_inputs();
      run_cycle();

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         int r;
         for (int i = 0; i < NREQ; i++) begin
            if (!bus.req_valid[i] && $urandom_range(1, 0) == 1)
               set_req(i, 1'b1,
                       ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 1)),
                       {$urandom, $urandom});
         end
         r = $urandom_range(31, 0);
         bus.sb_set_rd    = 5'(r);
         bus.sb_q_rd      = 5'(r);
         bus.sb_set_valid = ($urandom_range(1, 0) == 1) && !m_busy[r];
         bus.sb_q_rs1     = 5'($urandom_range(31, 0));
         bus.sb_q_rs2     = m_wen ? m_waddr : 5'($urandom_range(31, 0));
         run_cycle();
         if (last_grant >= 0) set_req(last_grant, 1'b0, 5'd0, 64'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/ysyx_22050854_wb_arbiter.md
# ysyx_22050854_wb_arbiter

Write-back arbiter and scoreboard for the 32×64-bit integer register file. Merges write-back requests from several execution units (ALU, LSU, MDU) onto the register file's single write port using round-robin arbitration. Tracks pending destination registers so issue logic can stall on RAW/WAW hazards. Sits between the execute/memory units and the register file write port (wen/waddr/wdata).

## Interface
- NREQ, 3, number of write-back requesters (index 0 = ALU, 1 = LSU, 2 = MDU)
- XLEN, 64, data width
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  requester i has a write-back pending
- req_ready  output  NREQ  grant to requester i; transfer when valid&&ready
- req_rd  input  5*NREQ  destination register of requester i, slice [5i+4:5i]
- req_data  input  XLEN*NREQ  write data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
- rf_wen  output  1  register file write enable (registered)
- rf_waddr  output  5  register file write address (registered)
- rf_wdata  output  XLEN  register file write data (registered)
- sb_set_valid  input  1  issue stage marks sb_set_rd busy this cycle
- sb_set_rd  input  5  destination register being issued
- sb_q_rs1, sb_q_rs2, sb_q_rd  input  5 each  scoreboard query addresses
- sb_busy_rs1, sb_busy_rs2, sb_busy_rd  output  1 each  combinational busy status of each query

## Operation
- Arbitration: rr_ptr (range 0..NREQ-1). Grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NREQ. At most one req_ready bit high per cycle; req_ready is combinational from req_valid and rr_ptr. req_ready[i] is never high without req_valid[i].
- On accept of requester g: rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
- Output stage: one register slot, always free (the register file absorbs one write per cycle). On accept: rf_wen<=1, rf_waddr<=req_rd[g], rf_wdata<=req_data[g]. With no accept, rf_wen<=0; waddr/wdata hold.
- rd = 0: the request is granted and consumed normally. rf_wen stays 0 for it. It does not affect the scoreboard.
- Scoreboard: busy[31:0], busy[0] constant 0.
  - Set: sb_set_valid && sb_set_rd!=0 sets busy[sb_set_rd].
  - Clear: busy[rf_waddr] clears on the edge that ends a cycle with rf_wen=1, i.e., the same edge at which the register file commits the write.
- Set while busy[sb_set_rd]=1 is a protocol violation. Issue must stall on sb_busy_rd. The bench asserts this never happens. If it does occur, set wins over a simultaneous clear of the same register.
- Set and clear of different registers on the same edge are independent.
- Queries: sb_busy_x = busy[sb_q_x]. There is no bypass: a register whose write is in rf_wen this cycle still reads busy=1, because register file reads are combinational and see the old value until the edge.
- Reset (async, any time): busy=0, rr_ptr=0, rf_wen=0, rf_waddr=0, rf_wdata=0. An accepted but uncommitted write is discarded. req_ready follows req_valid with rr_ptr=0 as soon as rst_n is released.

## Timing
- Accept in cycle t → rf_wen=1 in cycle t+1 → register file updated at the end of cycle t+1 → busy cleared at the same edge → sb_busy=0 from cycle t+2.
- Throughput: one write-back per cycle sustained.
- Worst-case wait for a continuously valid requester: NREQ-1 cycles.
- Requesters must hold req_valid/req_rd/req_data stable until accepted.
- Set in cycle t → busy visible to queries from cycle t+1.
- req_ready and sb_busy_* are combinational. There are no combinational paths from rf_* outputs.

## Test plan
- Reset: assert rst_n=0 mid-stream with rf_wen=1 → rf_wen, rf_waddr, rf_wdata and all busy bits read 0 immediately, without waiting for a clock edge. The first request after release is granted to the lowest valid index.
- Single write: set rd=5 at t0. ALU request rd=5, data=0xDEAD_BEEF at t2 → req_ready[0]=1 at t2; rf_wen=1, waddr=5, wdata=0xDEADBEEF at t3; sb_busy(5)=1 through t3 and 0 at t4.
- Round-robin: all three requesters valid continuously, rds 1/2/3 → grant order 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 on consecutive cycles with no bubbles.
- Priority rotation: rr_ptr=2 with only requesters 0 and 1 valid → requester 0 granted, then 1, then rr_ptr=2.
- x0 handling: a request with rd=0 and data=0xFFFF → req_ready=1, rf_wen stays 0. sb_set_rd=0 → sb_busy for register 0 always reads 0.
- Hazard boundary: busy[7] pending; the cycle rf_wen=1 with waddr=7 shows sb_busy_rs1(7)=1. The next cycle shows 0, and a new set of rd=7 there is legal; after it, busy=1 again.
